dsp_vec_seq: RTL and testbench
==============================

DSP_VEC_SEQ -- requirements
Module: dsp_vec_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the number of cycles waited for dsp_done before abort (used only with DSP_SEQ_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_op  input  2  operation: 00 add, 01 mul, 10 FIR, 11 sub.
REQ-006 SHALL have port cmd_ready  output  1  sequencer idle, command accepted.
REQ-007 SHALL have port in_valid  input  1  operand word valid.
REQ-008 SHALL have port in_data  input  32  operand word, Q16.16.
REQ-009 SHALL have port in_ready  output  1  operand word accepted.
REQ-010 SHALL have port dsp_start  output  1  one-cycle start pulse to DSP.
REQ-011 SHALL have port dsp_operation  output  2  latched cmd_op.
REQ-012 SHALL have ports dsp_A and dsp_B  output  8x32 each  operand banks (h coefficients and x samples).
REQ-013 SHALL have port dsp_result  input  8x32  DSP result vector.
REQ-014 SHALL have port dsp_done  input  1  DSP completion.
REQ-015 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 32) and out_last (output, 1), forming the result stream.
REQ-016 SHALL have ports busy (output, 1, FSM not IDLE) and err (output, 1, sticky timeout flag).

Function
REQ-017 SHALL implement the FSM IDLE -> LOAD_A -> LOAD_B -> START -> WAIT -> DRAIN -> IDLE.
REQ-018 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready SHALL latch cmd_op into dsp_operation, clear the 3-bit index, clear err, and go to LOAD_A.
REQ-019 LOAD_A/LOAD_B: in_ready=1; each in_valid&&in_ready SHALL write in_data to dsp_A[idx] or dsp_B[idx] respectively and increment idx; idx stalls when in_valid=0.
REQ-020 Index SHALL wrap 7->0 on the 8th accepted word, moving LOAD_A->LOAD_B or LOAD_B->START; exactly 16 words are consumed per command, A[0..7] then B[0..7].
REQ-021 START: dsp_start SHALL be high for exactly one cycle, then the FSM goes to WAIT.
REQ-022 WAIT: on dsp_done=1, SHALL capture all 8 dsp_result words into an internal result bank and go to DRAIN; dsp_done in any other state SHALL be ignored.
REQ-023 dsp_A, dsp_B and dsp_operation SHALL remain stable from START until WAIT exits.
REQ-024 DRAIN: out_valid=1, out_data=res[idx], out_last=(idx==7); idx advances on out_valid&&out_ready; after the handshake with out_last=1 the FSM SHALL go to IDLE.
REQ-025 While out_ready=0, out_data and out_last SHALL hold unchanged.
REQ-026 cmd_valid outside IDLE SHALL be ignored (cmd_ready=0); in_valid outside the LOAD states SHALL be ignored (in_ready=0).
REQ-027 No arithmetic SHALL be performed on data; words pass bit-exact.
REQ-028 Minimum latency, command to first out_valid: 16 load cycles + 1 START + DSP latency + 1 capture cycle.

Reset
REQ-029 On rst=1 at a clock edge, the FSM SHALL go to IDLE and idx, the dsp_A/dsp_B/result banks, dsp_operation, dsp_start, out_valid, out_last, out_data, busy and err SHALL all be 0, with cmd_ready=1.
REQ-030 Reset mid-operation (any state) SHALL abort with no further dsp_start or out_valid; partially loaded words are discarded.

Configuration
REQ-031 With DSP_SEQ_TIMEOUT_EN defined: a WAIT cycle counter SHALL run; if dsp_done is not seen within TIMEOUT_CYCLES cycles, err SHALL be set to 1 and the FSM SHALL go to IDLE without DRAIN.
REQ-032 Without DSP_SEQ_TIMEOUT_EN: no counter SHALL be present, err SHALL be constant 0, and WAIT SHALL hold indefinitely.

Verification
REQ-033 Reset: assert rst for 2 cycles -> cmd_ready=1, busy=0, out_valid=0, dsp_A[0..7]=0.
REQ-034 Add load: cmd_op=00, stream A=0x10000,0x30000,...,0xF0000 and B=0x20000,...,0x100000 -> single dsp_start pulse, dsp_operation=00, dsp_A[7]=0xF0000, dsp_B[7]=0x100000.
REQ-035 Drain: dsp_done with results 0x30000,0x70000,...,0x1F0000 -> 8 out words in order, out_last only on 0x1F0000, then cmd_ready=1.
REQ-036 Backpressure and gaps: in_valid low 2 cycles after word 3 -> idx holds at 3; out_ready low 3 cycles at word 2 -> out_data held at 0xB0000.
REQ-037 Reset mid-LOAD_B after 5 B words -> IDLE, no dsp_start; next FIR command (10) loads 16 fresh words correctly.
REQ-038 Timeout (macro on, TIMEOUT_CYCLES=64): no dsp_done -> err=1 after 64 WAIT cycles, FSM in IDLE, out_valid never 1; with macro off -> still busy at cycle 200.

Source files
------------

// File: rtl/dsp_vec_seq_if.sv
// Stream-side bundle for dsp_vec_seq: command, operand-word and result streams.
// master = traffic source/sink driving the sequencer, slave = the sequencer itself.
interface dsp_vec_seq_if;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_ready;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output cmd_valid, cmd_op, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  cmd_valid, cmd_op, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/dsp_vec_seq.sv
// Vector sequencer: loads 8 A + 8 B operand words, kicks the DSP, captures its
// 8-word result and streams it out. Optional WAIT timeout under DSP_SEQ_TIMEOUT_EN.
module dsp_vec_seq #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  dsp_vec_seq_if.slave     bus,
  output logic             dsp_start,
  output logic [1:0]       dsp_operation,
  output logic [7:0][31:0] dsp_A,
  output logic [7:0][31:0] dsp_B,
  input  logic [7:0][31:0] dsp_result,
  input  logic             dsp_done,
  output logic             busy,
  output logic             err,
  output logic [2:0]       state_dbg
);

  // All streams use valid/ready: a word moves on a rising edge where both
  // valid and ready are high; ready is asserted only in the state that consumes.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       idx;
  logic [7:0][31:0] res;
  logic             cmd_ready_c, in_ready_c, out_valid_c, out_last_c;
  logic [31:0]      out_data_c;
  logic             timeout_c;

`ifdef DSP_SEQ_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_cnt;
  logic          err_q;

  assign timeout_c = (state == WAIT) && !dsp_done && (wait_cnt == CNT_LAST);
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && bus.cmd_valid) err_q <= 1'b0;
      if (state == START) wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (timeout_c) err_q <= 1'b1;
    end
  end
`else
  assign timeout_c = 1'b0;
  // Without the timeout there is no error source; both arms tie err low.
  if (TIMEOUT_CYCLES > 0) begin : g_err_tied
    assign err = 1'b0;
  end else begin : g_err_tied_alt
    assign err = 1'b0;
  end
`endif

  always_comb begin
    state_nxt   = state;
    cmd_ready_c = 1'b0;
    in_ready_c  = 1'b0;
    dsp_start   = 1'b0;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    out_data_c  = '0;
    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) state_nxt = LOAD_A;
      end
      LOAD_A: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && idx == 3'd7) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && idx == 3'd7) state_nxt = START;
      end
      START: begin
        dsp_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (dsp_done)       state_nxt = DRAIN;
        else if (timeout_c) state_nxt = IDLE;
      end
      DRAIN: begin
        out_valid_c = 1'b1;
        out_data_c  = res[idx];
        out_last_c  = (idx == 3'd7);
        if (bus.out_ready && idx == 3'd7) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      dsp_A         <= '0;
      dsp_B         <= '0;
      res           <= '0;
      dsp_operation <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          dsp_operation <= bus.cmd_op;
          idx           <= '0;
        end
        LOAD_A: if (bus.in_valid) begin
          dsp_A[idx] <= bus.in_data;
          idx        <= idx + 3'd1;
        end
        LOAD_B: if (bus.in_valid) begin
          dsp_B[idx] <= bus.in_data;
          idx        <= idx + 3'd1;
        end
        WAIT: if (dsp_done) res <= dsp_result;
        DRAIN: if (bus.out_ready) idx <= idx + 3'd1;
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign bus.out_last  = out_last_c;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_dsp_vec_seq.sv
// Directed bench for dsp_vec_seq: reset, add load with input gaps, drain with
// backpressure, reset during LOAD_B, FIR command, and WAIT timeout behaviour.
module tb_dsp_vec_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsp_vec_seq_if bus();
  logic             dsp_start;
  logic [1:0]       dsp_operation;
  logic [7:0][31:0] dsp_A, dsp_B, dsp_result;
  logic             dsp_done, busy, err;
  logic [2:0]       state_dbg;

  dsp_vec_seq #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .dsp_start(dsp_start), .dsp_operation(dsp_operation),
    .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_result(dsp_result),
    .dsp_done(dsp_done), .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int outv_cnt = 0;
  logic [31:0] exp_q[$];

  // Outputs are stable mid-cycle, so event counting happens on the falling edge.
  always @(negedge clk) begin
    if (dsp_start) start_cnt++;
    if (bus.out_valid) outv_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    check("cmd_ready_idle", 256'(bus.cmd_ready), 256'(1));
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // Streams 16 words; gap_at inserts two idle cycles before word gap_at (< 8).
  task automatic load16(input logic [31:0] w[16], input int gap_at);
    for (int i = 0; i < 16; i++) begin
      if (i == gap_at) begin
        repeat (2) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
          check("gap_hold_A", 256'(dsp_A[gap_at]), 256'(0));
          check("gap_prev_A", 256'(dsp_A[gap_at-1]), 256'(w[gap_at-1]));
        end
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = w[i];
      check("in_ready_load", 256'(bus.in_ready), 256'(1));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("dsp_start_pulse", 256'(dsp_start), 256'(1));
    check("in_ready_start", 256'(bus.in_ready), 256'(0));
  endtask

  task automatic check_banks(input logic [31:0] w[16], input logic [1:0] op);
    logic [7:0][31:0] ea, eb;
    for (int i = 0; i < 8; i++) begin
      ea[i] = w[i];
      eb[i] = w[i+8];
    end
    check("bank_A", dsp_A, ea);
    check("bank_B", dsp_B, eb);
    check("dsp_operation", 256'(dsp_operation), 256'(op));
  endtask

  task automatic finish_dsp(input logic [7:0][31:0] r, input int stall_at);
    logic [7:0][31:0] a_snap;
    logic [1:0]       op_snap;
    int k, stalled, guard;
    a_snap  = dsp_A;
    op_snap = dsp_operation;
    repeat (3) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hDEAD_BEEF;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b11;
      check("dsp_start_low_wait", 256'(dsp_start), 256'(0));
      check("in_ready_wait", 256'(bus.in_ready), 256'(0));
      check("cmd_ready_wait", 256'(bus.cmd_ready), 256'(0));
      check("busy_wait", 256'(busy), 256'(1));
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.cmd_valid = 1'b0;
    check("bank_A_stable", dsp_A, a_snap);
    check("op_stable", 256'(dsp_operation), 256'(op_snap));
    dsp_result = r;
    dsp_done   = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(r[i]);
    @(negedge clk);
    dsp_done   = 1'b0;
    dsp_result = '1;
    k = 0; stalled = 0; guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
      check("out_valid_drain", 256'(bus.out_valid), 256'(1));
      if (k == stall_at && stalled < 3) begin
        bus.out_ready = 1'b0;
        stalled++;
        check("out_data_held", 256'(bus.out_data), 256'(exp_q[0]));
        check("out_last_held", 256'(bus.out_last), 256'(0));
      end else begin
        logic [31:0] e;
        bus.out_ready = 1'b1;
        e = exp_q.pop_front();
        check("out_data", 256'(bus.out_data), 256'(e));
        check("out_last", 256'(bus.out_last), 256'(exp_q.size() == 0));
        k++;
      end
    end
    check("drain_words_left", 256'(exp_q.size()), 256'(0));
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_after", 256'(bus.out_valid), 256'(0));
    check("cmd_ready_after", 256'(bus.cmd_ready), 256'(1));
    check("busy_after", 256'(busy), 256'(0));
  endtask

  initial begin
    logic [31:0]      w_add[16], w_fir[16], w_sub[16];
    logic [7:0][31:0] r_add, r_fir;
    int s, ov, n;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.out_ready = 1'b0;
    dsp_done = 1'b0; dsp_result = '0;
    for (int i = 0; i < 8; i++) begin
      w_add[i]   = 32'((2*i + 1) << 16);
      w_add[i+8] = 32'((2*i + 2) << 16);
      r_add[i]   = 32'((4*i + 3) << 16);
      r_fir[i]   = 32'hC000_0000 + 32'(i * 32'h0101);
    end
    for (int i = 0; i < 16; i++) begin
      w_fir[i] = 32'h000A_0000 + 32'(i * 32'h1111);
      w_sub[i] = 32'h8000_0000 - 32'(i);
    end

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_cmd_ready", 256'(bus.cmd_ready), 256'(1));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_out_valid", 256'(bus.out_valid), 256'(0));
    check("rst_dsp_A", dsp_A, 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_state", 256'(state_dbg), 256'(0));

    // Add command with input gap after 3 words, drain with stall on word 2
    send_cmd(2'b00);
    check("busy_load", 256'(busy), 256'(1));
    load16(w_add, 3);
    check_banks(w_add, 2'b00);
    check("dsp_A7_add", 256'(dsp_A[7]), 256'(32'h000F_0000));
    check("dsp_B7_add", 256'(dsp_B[7]), 256'(32'h0010_0000));
    finish_dsp(r_add, 2);
    check("start_count_add", 256'(start_cnt), 256'(1));

    // Reset during LOAD_B after 5 B words
    send_cmd(2'b10);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = w_sub[i];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("partial_B4", 256'(dsp_B[4]), 256'(w_sub[12]));
    rst = 1'b1;
    s = start_cnt;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_cmd_ready", 256'(bus.cmd_ready), 256'(1));
    check("midrst_busy", 256'(busy), 256'(0));
    check("midrst_dsp_A", dsp_A, 256'(0));
    check("midrst_dsp_B", dsp_B, 256'(0));
    repeat (5) @(negedge clk);
    check("midrst_no_start", 256'(start_cnt), 256'(s));

    // FIR command after the aborted one
    send_cmd(2'b10);
    load16(w_fir, 99);
    check_banks(w_fir, 2'b10);
    finish_dsp(r_fir, -1);
    check("start_count_fir", 256'(start_cnt), 256'(s + 1));

    // WAIT with no dsp_done
    send_cmd(2'b11);
    load16(w_sub, 99);
    ov = outv_cnt;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (!busy) break;
    end
`ifdef DSP_SEQ_TIMEOUT_EN
    check("timeout_cycles", 256'(n), 256'(65));
    check("timeout_err", 256'(err), 256'(1));
    check("timeout_idle", 256'(state_dbg), 256'(0));
    check("timeout_cmd_ready", 256'(bus.cmd_ready), 256'(1));
`else
    check("no_timeout_cycles", 256'(n), 256'(200));
    check("no_timeout_busy", 256'(busy), 256'(1));
    check("no_timeout_err", 256'(err), 256'(0));
    check("no_timeout_state", 256'(state_dbg), 256'(4));
`endif
    check("timeout_no_out_valid", 256'(outv_cnt), 256'(ov));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
